stopwatch_ctrl: RTL

//   Sequencing controller for the one-second timer. Turns start/stop, lap and clear button pulses into
//   the timer's enable and clear. Counts the timer's second_tick into a minutes:seconds value.

---
 rtl/stopwatch_pkg.sv | 14 +
 rtl/sw_time_counter.sv | 46 ++++
 rtl/stopwatch_ctrl.sv | 118 +++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// Provides the FSM state type and the seconds modulus.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        LAP  = 2'd3
    } sw_state_t;

    localparam logic [5:0] SEC_MAX = 6'd59;

endpackage

// File: rtl/sw_time_counter.sv
// Minutes:seconds modulus counter.
// Ports: clk, rst (sync, active-high), inc, clr,
//        sec/min (registered count), wrap (1-cycle pulse on wrap to 00:00).
module sw_time_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX_MINUTES = 60,
    localparam int MIN_W = $clog2(MAX_MINUTES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [5:0]       sec,
    output logic [MIN_W-1:0] min,
    output logic             wrap
);

    localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MAX_MINUTES - 1);

    // clr has priority over inc, so a tick in the clear cycle is lost
    // and never produces a wrap pulse.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sec  <= '0;
            min  <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (inc) begin
                if (sec == SEC_MAX) begin
                    sec <= '0;
                    if (min == MIN_LAST) begin
                        min  <= '0;
                        wrap <= 1'b1;
                    end else begin
                        min <= min + 1'b1;
                    end
                end else begin
                    sec <= sec + 6'd1;
                end
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: FSM, lap snapshot and timer handshake.
// Ports: clk, rst (sync, active-high), start_stop/lap/clear/second_tick pulses;
//        timer_enable, timer_clear, disp_sec, disp_min, running, lap_active, overflow.
// Macro STOPWATCH_LAP_EN enables the LAP state and snapshot registers.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int MAX_MINUTES = 60,
    localparam int MIN_W = $clog2(MAX_MINUTES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_stop,
    input  logic             lap,
    input  logic             clear,
    input  logic             second_tick,
    output logic             timer_enable,
    output logic             timer_clear,
    output logic [5:0]       disp_sec,
    output logic [MIN_W-1:0] disp_min,
    output logic             running,
    output logic             lap_active,
    output logic             overflow
);

    sw_state_t        state;
    sw_state_t        nxt;
    logic [5:0]       cnt_sec;
    logic [MIN_W-1:0] cnt_min;
    logic             counting;

    // Ticks are qualified by the registered state only.
    assign counting = second_tick && (state == RUN || state == LAP);

    sw_time_counter #(
        .MAX_MINUTES(MAX_MINUTES)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (counting),
        .clr  (clear),
        .sec  (cnt_sec),
        .min  (cnt_min),
        .wrap (overflow)
    );

    always_comb begin
        nxt = state;
        if (clear) begin
            nxt = IDLE;
        end else if (start_stop) begin
            case (state)
                IDLE:    nxt = RUN;
                RUN:     nxt = STOP;
                STOP:    nxt = RUN;
                LAP:     nxt = STOP;
                default: nxt = IDLE;
            endcase
        end
`ifdef STOPWATCH_LAP_EN
        else if (lap) begin
            case (state)
                RUN:     nxt = LAP;
                LAP:     nxt = RUN;
                default: nxt = state;
            endcase
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            timer_enable <= 1'b0;
            timer_clear  <= 1'b0;
            running      <= 1'b0;
        end else begin
            state        <= nxt;
            timer_enable <= (nxt == RUN) || (nxt == LAP);
            timer_clear  <= clear;
            running      <= (nxt == RUN) || (nxt == LAP);
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic [5:0]       snap_sec;
    logic [MIN_W-1:0] snap_min;

    // Snapshot captures the pre-increment count on entry to LAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_sec   <= '0;
            snap_min   <= '0;
            lap_active <= 1'b0;
        end else begin
            lap_active <= (nxt == LAP);
            if (clear) begin
                snap_sec <= '0;
                snap_min <= '0;
            end else if (state == RUN && nxt == LAP) begin
                snap_sec <= cnt_sec;
                snap_min <= cnt_min;
            end
        end
    end

    assign disp_sec = (state == LAP) ? snap_sec : cnt_sec;
    assign disp_min = (state == LAP) ? snap_min : cnt_min;
`else
    logic unused_lap;

    assign unused_lap = lap;
    assign lap_active = 1'b0;
    assign disp_sec   = cnt_sec;
    assign disp_min   = cnt_min;
`endif

endmodule
